vga_scan_mixer: RTL and testbench



---
 rtl/vga_scan_mixer.sv | 131 +++++++++++++
 tb/tb_vga_scan_mixer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_mixer.sv
// rtl/vga_scan_mixer.sv - VGA 640x480 timing, pixel request bus and layer priority compositor
`ifndef H_DISP_LEN
`define H_DISP_LEN 10
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 10
`endif
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif

module vga_scan_mixer #(
  parameter int CLK_DIV   = 10,
  parameter int H_DISP    = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISP    = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int LAYER_NUM = 4,
  parameter logic [`COLOR_RGB_DEPTH-1:0] BG_COLOR = 12'h000
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  output logic [`H_DISP_LEN-1:0]                  req_x_addr_o,
  output logic [`V_DISP_LEN-1:0]                  req_y_addr_o,
  output logic                                    req_valid_o,
  input  logic [LAYER_NUM*`COLOR_RGB_DEPTH-1:0]   layer_rgb_i,
  input  logic [LAYER_NUM-1:0]                    layer_alpha_i,
  output logic                                    vga_hs_o,
  output logic                                    vga_vs_o,
  output logic                                    vga_de_o,
  output logic [`COLOR_RGB_DEPTH-1:0]             vga_rgb_o,
  output logic                                    frame_start_o
);
  localparam int D       = `COLOR_RGB_DEPTH;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP_C   = HW'(H_DISP);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_DISP + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_DISP + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP_C   = VW'(V_DISP);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_DISP + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_DISP + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          vga_hs_q, vga_hs_d;
  logic          vga_vs_q, vga_vs_d;
  logic          vga_de_q, vga_de_d;
  logic [D-1:0]  vga_rgb_q, vga_rgb_d;
  logic          frame_start_q, frame_start_d;

  logic          pix_tick, active, h_last, v_last;
  logic [D-1:0]  mixed;

  always_comb begin
    pix_tick = (div_cnt_q == DIV_LAST);
    active   = (h_cnt_q < H_DISP_C) && (v_cnt_q < V_DISP_C);
    h_last   = (h_cnt_q == H_LAST);
    v_last   = (v_cnt_q == V_LAST);

    // Walk from lowest priority upward so layer 0 wins when several are opaque.
    mixed = BG_COLOR;
    for (int k = LAYER_NUM - 1; k >= 0; k--) begin
      if (layer_alpha_i[k]) mixed = layer_rgb_i[k*D +: D];
    end

    div_cnt_d     = pix_tick ? '0 : div_cnt_q + 1'b1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    vga_hs_d      = vga_hs_q;
    vga_vs_d      = vga_vs_q;
    vga_de_d      = vga_de_q;
    vga_rgb_d     = vga_rgb_q;
    frame_start_d = 1'b0;

    if (pix_tick) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      vga_de_d      = active;
      vga_rgb_d     = active ? mixed : '0;
      vga_hs_d      = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
      vga_vs_d      = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
      frame_start_d = h_last && v_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_de_q      <= 1'b0;
      vga_rgb_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_de_q      <= vga_de_d;
      vga_rgb_q     <= vga_rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  // The request address is held for the whole pixel slot so layers can settle.
  assign req_x_addr_o  = active ? `H_DISP_LEN'(h_cnt_q) : '0;
  assign req_y_addr_o  = active ? `V_DISP_LEN'(v_cnt_q) : '0;
  assign req_valid_o   = active;
  assign vga_hs_o      = vga_hs_q;
  assign vga_vs_o      = vga_vs_q;
  assign vga_de_o      = vga_de_q;
  assign vga_rgb_o     = vga_rgb_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_scan_mixer.sv
// tb/tb_vga_scan_mixer.sv - directed bench for vga_scan_mixer (full timing plus a scaled-down frame instance)
`timescale 1ns/1ps

module tb_vga_scan_mixer;
  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic        rst_n;
  logic [47:0] layer_rgb;
  logic [3:0]  layer_alpha;
  logic [9:0]  req_x, req_y;
  logic        req_valid, hs, vs, de, fs;
  logic [11:0] rgb;

  logic [47:0] s_layer_rgb;
  logic [3:0]  s_layer_alpha;
  logic [9:0]  s_req_x, s_req_y;
  logic        s_req_valid, s_hs, s_vs, s_de, s_fs;
  logic [11:0] s_rgb;

  vga_scan_mixer u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_x_addr_o(req_x), .req_y_addr_o(req_y), .req_valid_o(req_valid),
    .layer_rgb_i(layer_rgb), .layer_alpha_i(layer_alpha),
    .vga_hs_o(hs), .vga_vs_o(vs), .vga_de_o(de), .vga_rgb_o(rgb),
    .frame_start_o(fs)
  );

  // Frame of 15x10 pixels at 2 clks/pixel: 300 clks per frame, vsync on lines 7..8.
  vga_scan_mixer #(
    .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n),
    .req_x_addr_o(s_req_x), .req_y_addr_o(s_req_y), .req_valid_o(s_req_valid),
    .layer_rgb_i(s_layer_rgb), .layer_alpha_i(s_layer_alpha),
    .vga_hs_o(s_hs), .vga_vs_o(s_vs), .vga_de_o(s_de), .vga_rgb_o(s_rgb),
    .frame_start_o(s_fs)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] prev_rgb, v;
    int pix, h_now, hprev, k, p, vl;
    int bad_req, bad_rgb, bad_hs, bad_de, fs_seen;
    int hs_low, first_fall, second_fall;
    logic prev_hs;
    int s_bad_vs, s_bad_fs, s_vs_low, s_fs_cnt, s_first_fs;
    logic exp_vs, exp_fs;

    rst_n = 1'b0;
    layer_rgb = '0;
    layer_alpha = '0;
    s_layer_rgb = '0;
    s_layer_alpha = '0;
    step(3);
    rst_n = 1'b1;
    layer_rgb = {12'h00F, 12'h0F0, 12'hF00, 12'hABC};
    layer_alpha = 4'b0001;

    // Mid-line state before the asynchronous reset
    step(2000);
    check("midline_x", 32'(req_x), 32'd200);
    check("midline_de", 32'(de), 32'd1);
    check("midline_rgb", 32'(rgb), 32'hABC);

    #1 rst_n = 1'b0;
    #1;
    check("rst_req_x", 32'(req_x), 32'd0);
    check("rst_req_y", 32'(req_y), 32'd0);
    check("rst_req_valid", 32'(req_valid), 32'd1);
    check("rst_hs", 32'(hs), 32'd1);
    check("rst_vs", 32'(vs), 32'd1);
    check("rst_de", 32'(de), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_fs", 32'(fs), 32'd0);

    // Release with layers 1 and 2 opaque: layer 1 wins, first update 10 clks later
    repeat (3) @(posedge clk);
    #1;
    layer_rgb = {12'h00F, 12'h0F0, 12'hF00, 12'h111};
    layer_alpha = 4'b0110;
    rst_n = 1'b1;
    check("rel_req_x", 32'(req_x), 32'd0);
    check("rel_req_valid", 32'(req_valid), 32'd1);
    step(9);
    check("pre_slot_rgb", 32'(rgb), 32'd0);
    check("pre_slot_de", 32'(de), 32'd0);
    step(1);
    check("slot0_rgb", 32'(rgb), 32'hF00);
    check("slot0_de", 32'(de), 32'd1);

    layer_alpha = 4'b0000;
    step(10);
    check("bg_rgb", 32'(rgb), 32'h000);
    check("bg_de", 32'(de), 32'd1);

    layer_alpha = 4'b1111;
    step(10);
    check("prio_rgb", 32'(rgb), 32'h111);

    // Layer 3 alone, colour changing every pixel slot
    layer_alpha = 4'b1000;
    prev_rgb = 12'h111;
    for (int i = 0; i < 4; i++) begin
      v = 12'h00F ^ 12'(i << 4);
      layer_rgb[47:36] = v;
      step(5);
      check("l3_mid_slot", 32'(rgb), 32'(prev_rgb));
      step(5);
      check("l3_slot_end", 32'(rgb), 32'(v));
      prev_rgb = v;
    end

    // Two full lines with every layer opaque, compared per clock to a timing model
    layer_rgb = {12'h00F, 12'h0F0, 12'hF00, 12'hABC};
    layer_alpha = 4'b1111;
    do_reset();
    bad_req = 0; bad_rgb = 0; bad_hs = 0; bad_de = 0; fs_seen = 0;
    hs_low = 0; first_fall = -1; second_fall = -1; prev_hs = 1'b1;
    for (int n = 1; n <= 16000; n++) begin
      step(1);
      pix = n / 10;
      h_now = pix % 800;
      if (req_valid !== (h_now < 640)) bad_req++;
      if (req_x !== ((h_now < 640) ? 10'(h_now) : 10'd0)) bad_req++;
      if (n < 10) begin
        if (rgb !== 12'h000) bad_rgb++;
        if (hs !== 1'b1) bad_hs++;
        if (de !== 1'b0) bad_de++;
      end else begin
        hprev = (pix - 1) % 800;
        if (rgb !== ((hprev < 640) ? 12'hABC : 12'h000)) bad_rgb++;
        if (hs !== !(hprev >= 656 && hprev < 752)) bad_hs++;
        if (de !== (hprev < 640)) bad_de++;
      end
      if (fs !== 1'b0) fs_seen++;
      if (n <= 8000 && hs === 1'b0) hs_low++;
      if (prev_hs === 1'b1 && hs === 1'b0) begin
        if (first_fall < 0) first_fall = n;
        else if (second_fall < 0) second_fall = n;
      end
      prev_hs = hs;
    end
    check("line_req_bus", 32'(bad_req), 32'd0);
    check("line_rgb_blank", 32'(bad_rgb), 32'd0);
    check("line_hs_model", 32'(bad_hs), 32'd0);
    check("line_de_model", 32'(bad_de), 32'd0);
    check("line_no_fs", 32'(fs_seen), 32'd0);
    check("hs_low_clks", 32'(hs_low), 32'd960);
    check("hs_first_fall", 32'(first_fall), 32'd6570);
    check("line_period", 32'(second_fall - first_fall), 32'd8000);

    // Scaled frame: vsync width and frame_start cadence
    do_reset();
    s_bad_vs = 0; s_bad_fs = 0; s_vs_low = 0; s_fs_cnt = 0; s_first_fs = -1;
    for (int n = 1; n <= 700; n++) begin
      step(1);
      k = n / 2;
      exp_vs = 1'b1;
      exp_fs = 1'b0;
      if (k > 0) begin
        p = (k - 1) % 150;
        vl = p / 15;
        exp_vs = !(vl >= 7 && vl < 9);
        exp_fs = (n % 2 == 0) && (p == 149);
      end
      if (s_vs !== exp_vs) s_bad_vs++;
      if (s_fs !== exp_fs) s_bad_fs++;
      if (s_vs === 1'b0) s_vs_low++;
      if (s_fs === 1'b1) begin
        s_fs_cnt++;
        if (s_first_fs < 0) s_first_fs = n;
      end
    end
    check("frame_vs_model", 32'(s_bad_vs), 32'd0);
    check("frame_vs_low", 32'(s_vs_low), 32'd120);
    check("frame_fs_model", 32'(s_bad_fs), 32'd0);
    check("frame_fs_count", 32'(s_fs_cnt), 32'd2);
    check("frame_fs_first", 32'(s_first_fs), 32'd300);

    // Reset pulse mid-frame, then the next frame_start lands one full frame after release
    do_reset();
    step(146);
    rst_n = 1'b0;
    step(3);
    check("midframe_rst_fs", 32'(s_fs), 32'd0);
    rst_n = 1'b1;
    s_first_fs = -1;
    for (int n = 1; n <= 400 && s_first_fs < 0; n++) begin
      step(1);
      if (s_fs === 1'b1) s_first_fs = n;
    end
    check("midframe_next_fs", 32'(s_first_fs), 32'd300);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
